rv32e_alu_issue: RTL
====================

# rv32e_alu_issue

Decode-and-issue stage that sits directly in front of `rv32e_alu` and drives its `op`/`a`/`b` inputs. It accepts one RV32E instruction per cycle with its source-register values and PC, and maps it to an ALU op code, operand pair, destination and control flags. The result goes into a two-entry skid buffer with valid/ready handshakes on both sides, so the stage sustains full throughput while `in_ready` comes straight from a flop.

## Interface
Parameters:
- `XLEN`, 32: datapath width; only 32 is supported.

Ports:
- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous discard of all buffered entries.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage can accept a beat; equals NOT skid-occupied AND NOT `flush`.
- `instr`  in  32  instruction word.
- `pc`  in  32  instruction address.
- `rs1_data`, `rs2_data`  in  32 each  register-file read values.
- `out_valid`  out  1  issued entry present.
- `out_ready`  in  1  ALU/writeback consumes the entry.
- `alu_op`  out  4  ALU op code (package encoding).
- `alu_a`, `alu_b`  out  32 each  ALU operands.
- `rd_addr`  out  4  destination register.
- `rd_we`  out  1  write-back enable.
- `is_branch`  out  1  `alu_op` is a branch compare; the result bit is the taken flag.
- `illegal`  out  1  unsupported or non-RV32E encoding.

## Operation
Decode of `opcode = instr[6:0]`, `f3 = instr[14:12]`, `f7 = instr[31:25]`:
- OP (0110011):
  - `f7 = 0`: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - `f7 = 0100000`: f3 000 SUB, 101 SRA.
  - Any other f7/f3 pair is illegal.
  - Operands: a = `rs1_data`, b = `rs2_data`.
- OP-IMM (0010011):
  - Same f3 map as OP; SUB does not exist.
  - b = I-immediate, sign-extended.
  - Shifts: f3 001 requires `f7 = 0`; f3 101 selects SRL when `f7 = 0` and SRA when `f7 = 0100000`; b = `{27'b0, instr[24:20]}`.
- LUI (0110111): ADD, a = 0, b = `{instr[31:12], 12'b0}`.
- AUIPC (0010111): ADD, a = `pc`, b = U-immediate.
- BRANCH (1100011):
  - f3 000 SEQ, 001 SNE, 100 SLT, 101 SGE, 110 SLTU, 111 SGEU; 010/011 illegal.
  - a = `rs1_data`, b = `rs2_data`, `is_branch` = 1.
- Any other opcode is illegal.
- RV32E check: bit 4 set in any register field the format actually uses (rd, rs1, rs2) makes the instruction illegal.
- Illegal entries still issue, with `alu_op` = ADD, a = b = 0, `rd_we` = 0, `is_branch` = 0, `illegal` = 1.
- `rd_we` = 1 only for legal OP/OP-IMM/LUI/AUIPC with `rd != 0`; `rd_addr` = `instr[10:7]`.

Skid buffer (main register M drives the outputs; skid register S):
- Accept when `in_valid && in_ready`.
- Accepted beat goes to M if M is empty or M is draining (`out_valid && out_ready`); otherwise it goes to S.
- When M drains and S is full, S moves to M in the same cycle. Order is always preserved.
- `flush`:
  - Clears M and S valid bits in that cycle.
  - Forces `in_ready` to 0, so the concurrent input beat is not accepted.
  - Takes priority over every other event.
- Reset mid-operation drops all entries immediately, with no partial issue.

## Timing
- Latency: accepted at edge N, visible on the outputs in the following cycle (`out_valid` = 1 after edge N).
- Throughput: 1 beat/cycle while `out_ready` = 1.
- While `out_valid && !out_ready`, all payload outputs stay stable.
- `in_ready` is 0 exactly while S is occupied or `flush` = 1.
- Reset values: `out_valid` 0; `alu_op` 0; `alu_a`, `alu_b` 0; `rd_addr` 0; `rd_we`, `is_branch`, `illegal` 0; `in_ready` 1 once `flush` = 0.
- Full (M and S valid) plus `out_ready` = 1 plus `in_valid` = 1: S moves to M and `in_ready` = 0 this cycle; `in_ready` returns to 1 next cycle.

## Structure
- Package `rv32e_pkg` holds:
  - ALU op encodings: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, SEQ A, SNE B, SGE C, SGEU D, SGT E, SGTU F (shared with `rv32e_alu`).
  - Opcode constants.
  - The issue-payload struct (`alu_op`, `a`, `b`, `rd_addr`, `rd_we`, `is_branch`, `illegal`).
- Sub-module `rv32e_alu_decode`: purely combinational instruction-to-payload decode. The top level instantiates it and implements the skid buffer.

## Test plan
- `0x002081B3` (add x3,x1,x2), `rs1` = 5, `rs2` = 7 -> next cycle: op 0, a = 5, b = 7, rd 3, `rd_we` 1, `illegal` 0.
- `0x4040D193` (srai x3,x1,4), `rs1` = 0x80000000 -> op 7, b = 4. `0x402081B3` -> op 1.
- `0x123452B7` (lui x5) -> op 0, a = 0, b = 0x12345000, rd 5. AUIPC with `pc` = 0x100 -> a = 0x100.
- `0x0020C063` (blt x1,x2) -> op 8, `is_branch` 1, `rd_we` 0. `0x00208833` (rd = x16) -> `illegal` 1, op 0, a = b = 0.
- Backpressure: 3 back-to-back beats with `out_ready` held 0 -> beats 1 and 2 accepted, `in_ready` 0 from the third cycle. Release -> beats issue 1, 2, 3 in order, payload stable while stalled.
- `flush` asserted while M and S are full and `in_valid` = 1 -> `out_valid` 0 next cycle, nothing from the flushed or presented beats ever issues. `rst_n` low mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rv32e_pkg.sv
// Shared definitions for the RV32E ALU issue stage: ALU op codes, opcodes and the issue payload.
package rv32e_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0,
      ALU_SUB  = 4'h1,
      ALU_AND  = 4'h2,
      ALU_OR   = 4'h3,
      ALU_XOR  = 4'h4,
      ALU_SLL  = 4'h5,
      ALU_SRL  = 4'h6,
      ALU_SRA  = 4'h7,
      ALU_SLT  = 4'h8,
      ALU_SLTU = 4'h9,
      ALU_SEQ  = 4'hA,
      ALU_SNE  = 4'hB,
      ALU_SGE  = 4'hC,
      ALU_SGEU = 4'hD,
      ALU_SGT  = 4'hE,
      ALU_SGTU = 4'hF
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      alu_op_e     alu_op;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  rd_addr;
      logic        rd_we;
      logic        is_branch;
      logic        illegal;
   } issue_t;

   // Base funct3 map shared by OP and OP-IMM (funct7 = 0 variants).
   function automatic alu_op_e f3_to_op(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/rv32e_alu_decode.sv
// Combinational RV32E instruction decode into an ALU issue payload.
module rv32e_alu_decode
   import rv32e_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output issue_t      payload
);

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i;
   logic [31:0] imm_u;
   logic [31:0] shamt;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_u  = {instr[31:12], 12'b0};
   assign shamt  = {27'b0, instr[24:20]};

   alu_op_e     op;
   logic [31:0] a;
   logic [31:0] b;
   logic        legal;
   logic        use_rd;
   logic        use_rs1;
   logic        use_rs2;
   logic        writes;
   logic        branch;
   logic        bad;

   always_comb begin
      op      = ALU_ADD;
      a       = '0;
      b       = '0;
      legal   = 1'b0;
      use_rd  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      writes  = 1'b0;
      branch  = 1'b0;
      case (opcode)
         OPC_OP: begin
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            writes  = 1'b1;
            a       = rs1_data;
            b       = rs2_data;
            if (f7 == F7_BASE) begin
               legal = 1'b1;
               op    = f3_to_op(f3);
            end else if (f7 == F7_ALT && f3 == 3'b000) begin
               legal = 1'b1;
               op    = ALU_SUB;
            end else if (f7 == F7_ALT && f3 == 3'b101) begin
               legal = 1'b1;
               op    = ALU_SRA;
            end
         end
         OPC_OP_IMM: begin
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            writes  = 1'b1;
            legal   = 1'b1;
            a       = rs1_data;
            b       = imm_i;
            op      = f3_to_op(f3);
            // Shift-immediates reuse imm[11:5] as funct7, so it must be validated.
            if (f3 == 3'b001) begin
               b     = shamt;
               legal = (f7 == F7_BASE);
            end else if (f3 == 3'b101) begin
               b = shamt;
               if (f7 == F7_ALT) op = ALU_SRA;
               else              legal = (f7 == F7_BASE);
            end
         end
         OPC_LUI: begin
            use_rd = 1'b1;
            writes = 1'b1;
            legal  = 1'b1;
            b      = imm_u;
         end
         OPC_AUIPC: begin
            use_rd = 1'b1;
            writes = 1'b1;
            legal  = 1'b1;
            a      = pc;
            b      = imm_u;
         end
         OPC_BRANCH: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            branch  = 1'b1;
            legal   = 1'b1;
            a       = rs1_data;
            b       = rs2_data;
            case (f3)
               3'b000:  op = ALU_SEQ;
               3'b001:  op = ALU_SNE;
               3'b100:  op = ALU_SLT;
               3'b101:  op = ALU_SGE;
               3'b110:  op = ALU_SLTU;
               3'b111:  op = ALU_SGEU;
               default: legal = 1'b0;
            endcase
         end
         default: legal = 1'b0;
      endcase
   end

   // Registers x16..x31 do not exist in RV32E; only fields the format uses count.
   assign bad = !legal || (use_rd && instr[11]) || (use_rs1 && instr[19]) || (use_rs2 && instr[24]);

   always_comb begin
      payload           = '0;
      payload.rd_addr   = instr[10:7];
      payload.illegal   = bad;
      payload.alu_op    = bad ? ALU_ADD : op;
      payload.a         = bad ? '0 : a;
      payload.b         = bad ? '0 : b;
      payload.is_branch = !bad && branch;
      payload.rd_we     = !bad && writes && (instr[11:7] != 5'd0);
   end

endmodule

// File: rtl/rv32e_alu_issue.sv
// RV32E decode-and-issue stage: decode feeding a two-entry skid buffer with registered in_ready.
module rv32e_alu_issue
   import rv32e_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      alu_op,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      rd_addr,
   output logic            rd_we,
   output logic            is_branch,
   output logic            illegal
);

   issue_t dec;
   issue_t m_q, m_d;
   issue_t s_q, s_d;
   logic   m_valid_q, m_valid_d;
   logic   s_valid_q, s_valid_d;
   logic   accept;
   logic   drain;

   rv32e_alu_decode u_decode (
      .instr    (instr),
      .pc       (pc),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .payload  (dec)
   );

   assign in_ready = !s_valid_q && !flush;
   assign accept   = in_valid && in_ready;
   assign drain    = m_valid_q && out_ready;

   always_comb begin
      m_d       = m_q;
      s_d       = s_q;
      m_valid_d = m_valid_q;
      s_valid_d = s_valid_q;
      if (flush) begin
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else if (drain) begin
         // A full skid implies in_ready was low, so no new beat competes for M here.
         if (s_valid_q) begin
            m_d       = s_q;
            s_valid_d = 1'b0;
         end else if (accept) begin
            m_d = dec;
         end else begin
            m_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!m_valid_q) begin
            m_d       = dec;
            m_valid_d = 1'b1;
         end else begin
            s_d       = dec;
            s_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q       <= '0;
         s_q       <= '0;
         m_valid_q <= 1'b0;
         s_valid_q <= 1'b0;
      end else begin
         m_q       <= m_d;
         s_q       <= s_d;
         m_valid_q <= m_valid_d;
         s_valid_q <= s_valid_d;
      end
   end

   assign out_valid = m_valid_q;
   assign alu_op    = m_q.alu_op;
   assign alu_a     = m_q.a;
   assign alu_b     = m_q.b;
   assign rd_addr   = m_q.rd_addr;
   assign rd_we     = m_q.rd_we;
   assign is_branch = m_q.is_branch;
   assign illegal   = m_q.illegal;

endmodule
